// File: rtl/axi_mem_responder.sv
// Single-outstanding AXI slave answering 8-beat bursts from an internal store of 64-byte lines.
// Define AXI_MEM_SNOOP_EN to issue a MakeInvalid snoop for the line of every completed write.
module axi_mem_responder #(
  parameter int ID_WIDTH   = 13,
  parameter int ADDR_WIDTH = 64,
  parameter int MEM_LINES  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [63:0]           s_axi_wdata,
  input  logic [7:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [63:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  s_axi_acvalid,
  input  logic                  s_axi_acready,
  output logic [ADDR_WIDTH-1:0] s_axi_acaddr,
  output logic [3:0]            s_axi_acsnoop
);

  localparam int IDX_W = $clog2(MEM_LINES);

  typedef enum logic [2:0] {IDLE, RDATA, WDATA, WRESP, SNOOP} state_e;

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            offset_q, offset_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  mem_we;
  logic [IDX_W+2:0]      mem_idx;
  logic [63:0]           mem [MEM_LINES*8];
  logic                  unused_ok;

  // offset_q walks the beat within the line (wrapping for reads); cnt_q counts handshakes.
  assign mem_idx = {addr_q[IDX_W+5:6], offset_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      offset_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      offset_q <= offset_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      for (int i = 0; i < 8; i++) begin
        if (s_axi_wstrb[i]) mem[mem_idx][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    addr_d        = addr_q;
    offset_d      = offset_q;
    cnt_d         = cnt_q;
    mem_we        = 1'b0;
    s_axi_awready = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    case (state_q)
      IDLE: begin
        s_axi_awready = s_axi_awvalid;
        s_axi_arready = s_axi_arvalid && !s_axi_awvalid;
        if (s_axi_awvalid) begin
          state_d  = WDATA;
          id_d     = s_axi_awid;
          addr_d   = s_axi_awaddr;
          offset_d = 3'd0;
          cnt_d    = 3'd0;
        end else if (s_axi_arvalid) begin
          state_d  = RDATA;
          id_d     = s_axi_arid;
          addr_d   = s_axi_araddr;
          offset_d = s_axi_araddr[5:3];
          cnt_d    = 3'd0;
        end
      end
      RDATA: begin
        s_axi_rvalid = 1'b1;
        s_axi_rlast  = (cnt_q == 3'd7);
        if (s_axi_rready) begin
          offset_d = offset_q + 3'd1;
          cnt_d    = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = IDLE;
        end
      end
      WDATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid) begin
          mem_we   = 1'b1;
          offset_d = offset_q + 3'd1;
          cnt_d    = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = WRESP;
        end
      end
      WRESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) begin
`ifdef AXI_MEM_SNOOP_EN
          state_d = SNOOP;
`else
          state_d = IDLE;
`endif
        end
      end
      SNOOP: begin
        if (s_axi_acready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // IDs and read data are only presented while their channel is active, so reset clears them too.
  always_comb begin
    s_axi_bid     = (state_q == WRESP) ? id_q : '0;
    s_axi_rid     = (state_q == RDATA) ? id_q : '0;
    s_axi_rdata   = (state_q == RDATA) ? mem[mem_idx] : '0;
    s_axi_bresp   = 2'b00;
    s_axi_rresp   = 2'b00;
`ifdef AXI_MEM_SNOOP_EN
    s_axi_acvalid = (state_q == SNOOP);
    s_axi_acaddr  = (state_q == SNOOP) ? {addr_q[ADDR_WIDTH-1:6], 6'b0} : '0;
    s_axi_acsnoop = (state_q == SNOOP) ? 4'hD : 4'h0;
`else
    s_axi_acvalid = 1'b0;
    s_axi_acaddr  = '0;
    s_axi_acsnoop = 4'h0;
`endif
  end

`ifdef AXI_MEM_SNOOP_EN
  assign unused_ok = ^addr_q[5:0];
`else
  assign unused_ok = ^{addr_q[5:0], addr_q[ADDR_WIDTH-1:IDX_W+6]};
`endif

endmodule

// File: tb/tb_axi_mem_responder.sv
// Randomized self-checking bench for axi_mem_responder against a word-indexed memory model.
// Snoop checks follow AXI_MEM_SNOOP_EN, as in the design.
module tb_axi_mem_responder;

  localparam int IDW   = 13;
  localparam int AW    = 64;
  localparam int LINES = 1024;

  logic           clk = 1'b0;
  logic           reset;
  logic [IDW-1:0] s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [AW-1:0]  s_axi_awaddr, s_axi_araddr, s_axi_acaddr;
  logic           s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [63:0]    s_axi_wdata, s_axi_rdata;
  logic [7:0]     s_axi_wstrb;
  logic [1:0]     s_axi_bresp, s_axi_rresp;
  logic           s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic           s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic           s_axi_acvalid, s_axi_acready;
  logic [3:0]     s_axi_acsnoop;

  int vectors = 0;
  int errors  = 0;

  logic [63:0] model [int];
  logic [63:0] wd [8];
  logic [7:0]  ws [8];
  logic [63:0] line_pool [6];

  always #5 clk = ~clk;

  axi_mem_responder dut (
    .clk(clk), .reset(reset),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_bid(s_axi_bid),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .s_axi_acvalid(s_axi_acvalid), .s_axi_acready(s_axi_acready),
    .s_axi_acaddr(s_axi_acaddr), .s_axi_acsnoop(s_axi_acsnoop)
  );

  // A memory word is identified by its line (address / 64, wrapped to the store depth) and beat.
  function automatic int word_index(input logic [63:0] addr, input int beat);
    return int'((addr >> 6) % LINES) * 8 + beat;
  endfunction

  task automatic idle_inputs();
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; s_axi_acready = 1'b0;
  endtask

  // Tasks start and end just after a falling edge; inputs change there and outputs are sampled 1 ns later.
  task automatic write_burst(input logic [IDW-1:0] id, input logic [63:0] addr, input int snoop_stall);
    int n;
    int b;
    bit done;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
    #1;
    n = 0;
    while (s_axi_awready !== 1'b1 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    vectors++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL aw_handshake: awready=%b arready=%b, required awready=1 arready=0",
               s_axi_awready, s_axi_arready);
    end
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    b = 0; n = 0;
    while (b < 8 && n < 200) begin
      s_axi_wvalid = ($urandom_range(0, 3) != 0);
      s_axi_wdata  = wd[b];
      s_axi_wstrb  = ws[b];
      #1;
      vectors++;
      if (s_axi_wready !== 1'b1 || s_axi_arready !== 1'b0 || s_axi_bvalid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wdata_phase beat %0d: wready=%b arready=%b bvalid=%b, required 1/0/0",
                 b, s_axi_wready, s_axi_arready, s_axi_bvalid);
      end
      if (s_axi_wvalid) b++;
      @(negedge clk); n++;
    end
    s_axi_wvalid = 1'b0;
    for (int bt = 0; bt < 8; bt++) begin
      int w;
      logic [63:0] cur;
      w = word_index(addr, bt);
      cur = model.exists(w) ? model[w] : 64'hx;
      for (int i = 0; i < 8; i++) if (ws[bt][i]) cur[i*8 +: 8] = wd[bt][i*8 +: 8];
      model[w] = cur;
    end
    done = 1'b0; n = 0;
    while (!done && n < 100) begin
      s_axi_bready = ($urandom_range(0, 1) == 1);
      #1;
      if (s_axi_bvalid === 1'b1 && s_axi_bready) begin
        done = 1'b1;
        vectors++;
        if (s_axi_bid !== id || s_axi_bresp !== 2'b00) begin
          errors++;
          $display("[TB] FAIL bresp: bid=%h bresp=%0d, required bid=%h bresp=0", s_axi_bid, s_axi_bresp, id);
        end
      end
      @(negedge clk); n++;
    end
    s_axi_bready = 1'b0;
    if (!done) begin
      vectors++; errors++;
      $display("[TB] FAIL b_timeout: bvalid=%b, required 1 within 100 cycles", s_axi_bvalid);
    end
`ifdef AXI_MEM_SNOOP_EN
    for (int k = 0; k <= snoop_stall; k++) begin
      s_axi_acready = (k == snoop_stall);
      #1;
      vectors++;
      if (s_axi_acvalid !== 1'b1 || s_axi_acaddr !== (addr & ~64'h3F) || s_axi_acsnoop !== 4'hD ||
          s_axi_arready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL snoop cycle %0d: acvalid=%b acaddr=%h acsnoop=%h arready=%b, required 1/%h/d/0",
                 k, s_axi_acvalid, s_axi_acaddr, s_axi_acsnoop, s_axi_arready, addr & ~64'h3F);
      end
      @(negedge clk);
    end
    s_axi_acready = 1'b0;
    #1;
    vectors++;
    if (s_axi_acvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL snoop_release: acvalid=%b, required 0", s_axi_acvalid);
    end
`else
    #1;
    vectors++;
    if (snoop_stall >= 0 && (s_axi_acvalid !== 1'b0 || s_axi_acaddr !== '0 || s_axi_acsnoop !== 4'h0)) begin
      errors++;
      $display("[TB] FAIL no_snoop: acvalid=%b acaddr=%h acsnoop=%h, required all 0",
               s_axi_acvalid, s_axi_acaddr, s_axi_acsnoop);
    end
`endif
  endtask

  task automatic read_burst(input logic [IDW-1:0] id, input logic [63:0] addr, input int stall_pct);
    int n;
    int k;
    logic [63:0] exp;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    #1;
    n = 0;
    while (s_axi_arready !== 1'b1 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    vectors++;
    if (s_axi_arready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ar_handshake: arready=%b, required 1", s_axi_arready);
    end
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    k = 0; n = 0;
    while (k < 8 && n < 300) begin
      s_axi_rready = ($urandom_range(0, 99) >= stall_pct);
      #1;
      exp = model[word_index(addr, (int'(addr[5:3]) + k) % 8)];
      vectors++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== exp || s_axi_rid !== id ||
          s_axi_rresp !== 2'b00 || s_axi_rlast !== (k == 7)) begin
        errors++;
        $display("[TB] FAIL rbeat %0d: rvalid=%b rdata=%h rid=%h rresp=%0d rlast=%b, required 1/%h/%h/0/%b",
                 k, s_axi_rvalid, s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast, exp, id, k == 7);
      end
      if (s_axi_rready) k++;
      @(negedge clk); n++;
    end
    s_axi_rready = 1'b0;
    #1;
    vectors++;
    if (s_axi_rvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL r_end: rvalid=%b after 8th beat, required 0", s_axi_rvalid);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if ({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast,
         s_axi_acvalid} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: aw/ar/w/b/r/rlast/ac=%b, required 0000000",
               {s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_rvalid, s_axi_rlast,
                s_axi_acvalid});
    end
    vectors++;
    if (s_axi_bid !== '0 || s_axi_rid !== '0 || s_axi_bresp !== 2'b0 || s_axi_rresp !== 2'b0 ||
        s_axi_acaddr !== '0 || s_axi_acsnoop !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_fields: bid=%h rid=%h bresp=%0d rresp=%0d acaddr=%h acsnoop=%h, required 0",
               s_axi_bid, s_axi_rid, s_axi_bresp, s_axi_rresp, s_axi_acaddr, s_axi_acsnoop);
    end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    for (int b = 0; b < 8; b++) begin
      wd[b] = 64'h11 * (b + 1);
      ws[b] = 8'hFF;
    end
    write_burst(13'h0A5, 64'h1000, 1);
    read_burst(13'h133, 64'h1000, 0);
  endtask

  task automatic test_wrap();
    read_burst(13'h1F0F, 64'h1028, 30);
  endtask

  task automatic test_strobe();
    for (int b = 0; b < 8; b++) begin
      wd[b] = 64'hDEAD_BEEF_0000_0000 + b;
      ws[b] = 8'h00;
    end
    wd[0] = 64'hFFFFFFFF_AAAAAAAA;
    ws[0] = 8'h0F;
    write_burst(13'h002, 64'h1000, 0);
    read_burst(13'h003, 64'h1000, 20);
  endtask

  task automatic test_collision();
    for (int b = 0; b < 8; b++) begin
      wd[b] = {$urandom, $urandom};
      ws[b] = 8'($urandom);
    end
    s_axi_arid = 13'h0777; s_axi_araddr = 64'h1010; s_axi_arvalid = 1'b1;
    write_burst(13'h0555, 64'h1000, 2);
    read_burst(13'h0777, 64'h1010, 60);
  endtask

  task automatic test_snoop();
    for (int b = 0; b < 8; b++) begin
      wd[b] = {$urandom, $urandom};
      ws[b] = 8'hFF;
    end
    write_burst(13'h0ABC, 64'h2048, 3);
    read_burst(13'h0ABD, 64'h2048, 10);
  endtask

  task automatic test_reset_mid_read();
    s_axi_arid = 13'h0042; s_axi_araddr = 64'h1000; s_axi_arvalid = 1'b1;
    #1;
    vectors++;
    if (s_axi_arready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_ar: arready=%b, required 1", s_axi_arready);
    end
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (s_axi_rvalid !== 1'b1 || s_axi_rlast !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_beat3: rvalid=%b rlast=%b, required 1/0", s_axi_rvalid, s_axi_rlast);
    end
    reset = 1'b1;
    s_axi_rready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if (s_axi_rvalid !== 1'b0 || s_axi_rlast !== 1'b0 || s_axi_rid !== '0 || s_axi_wready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_abort: rvalid=%b rlast=%b rid=%h wready=%b, required all 0",
               s_axi_rvalid, s_axi_rlast, s_axi_rid, s_axi_wready);
    end
    read_burst(13'h0043, 64'h1018, 25);
  endtask

  // Random traffic over a small pool of lines whose addresses carry random bits above the index.
  task automatic test_random();
    logic [63:0] a;
    for (int p = 0; p < 6; p++) begin
      a = {$urandom, $urandom};
      a[15:6] = 10'(p * 97 + 300);
      line_pool[p] = a;
      for (int b = 0; b < 8; b++) begin
        wd[b] = {$urandom, $urandom};
        ws[b] = 8'hFF;
      end
      write_burst(13'($urandom), a, $urandom_range(0, 2));
    end
    for (int t = 0; t < 24; t++) begin
      a = {$urandom, $urandom};
      a[15:6] = line_pool[$urandom_range(0, 5)][15:6];
      if ($urandom_range(0, 1) == 0) begin
        for (int b = 0; b < 8; b++) begin
          wd[b] = {$urandom, $urandom};
          ws[b] = 8'($urandom);
        end
        write_burst(13'($urandom), a, $urandom_range(0, 2));
      end else begin
        read_burst(13'($urandom), a, $urandom_range(0, 60));
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_write_read();
    test_wrap();
    test_strobe();
    test_collision();
    test_snoop();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
